// File: rtl/ex_mem_debug_reader_if.sv
// rtl/ex_mem_debug_reader_if.sv - byte-stream handshake from the EX/MEM debug reader to the debug UART TX
interface ex_mem_debug_reader_if;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;

    modport master (output txData, output txValid, input txReady);
    modport slave  (input txData, input txValid, output txReady);
endinterface

// File: rtl/ex_mem_debug_reader.sv
// rtl/ex_mem_debug_reader.sv - snapshots the EX/MEM latch and streams it as a byte frame
// Optional macro DEBUG_FRAME_CHECKSUM_EN appends an XOR checksum byte to the frame.
module ex_mem_debug_reader #(
    parameter logic [7:0] HEADER_BYTE = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        debugReset,
    input  logic        start,
    input  logic [4:0]  writeRegister,
    input  logic [31:0] writeData,
    input  logic [31:0] aluOut,
    input  logic        regWrite,
    input  logic        memToReg,
    input  logic [3:0]  memWrite,
    input  logic [1:0]  memReadWidth,
    input  logic        eop,
    ex_mem_debug_reader_if.master tx,
    output logic        busy,
    output logic        done
);
`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = 4'd11;
`else
    localparam logic [3:0] LAST_IDX = 4'd10;
`endif

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t      state, stateNext;
    logic [3:0]  idx, idxNext;
    // Payload bytes 1..10 packed MSB-first, so byte n lives at [87-8n -: 8]
    logic [79:0] snapshot, snapshotNext;
    logic [7:0]  frameByte;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= 4'd0;
            snapshot <= '0;
        end else begin
            state    <= stateNext;
            idx      <= idxNext;
            snapshot <= snapshotNext;
        end
    end

    always_comb begin
        stateNext    = state;
        idxNext      = idx;
        snapshotNext = snapshot;
        if (debugReset) begin
            stateNext = IDLE;
            idxNext   = 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        snapshotNext = {eop, 2'b00, writeRegister, writeData, aluOut,
                                        regWrite, memToReg, memWrite, memReadWidth};
                        idxNext      = 4'd0;
                        stateNext    = SEND;
                    end
                end
                SEND: begin
                    if (tx.txReady) begin
                        if (idx == LAST_IDX) stateNext = DONE;
                        else                 idxNext   = idx + 4'd1;
                    end
                end
                DONE: begin
                    idxNext   = 4'd0;
                    stateNext = IDLE;
                end
                default: begin
                    idxNext   = 4'd0;
                    stateNext = IDLE;
                end
            endcase
        end
    end

`ifdef DEBUG_FRAME_CHECKSUM_EN
    logic [7:0] checksum;

    always_comb begin
        checksum = HEADER_BYTE;
        for (int i = 0; i < 10; i++) begin
            checksum = checksum ^ snapshot[8*i +: 8];
        end
    end
`endif

    always_comb begin
        frameByte = 8'h00;
        case (idx)
            4'd0:  frameByte = HEADER_BYTE;
            4'd1:  frameByte = snapshot[79:72];
            4'd2:  frameByte = snapshot[71:64];
            4'd3:  frameByte = snapshot[63:56];
            4'd4:  frameByte = snapshot[55:48];
            4'd5:  frameByte = snapshot[47:40];
            4'd6:  frameByte = snapshot[39:32];
            4'd7:  frameByte = snapshot[31:24];
            4'd8:  frameByte = snapshot[23:16];
            4'd9:  frameByte = snapshot[15:8];
            4'd10: frameByte = snapshot[7:0];
`ifdef DEBUG_FRAME_CHECKSUM_EN
            4'd11: frameByte = checksum;
`endif
            default: frameByte = 8'h00;
        endcase
    end

    // Outputs are pure functions of state so a stall holds txData/txValid for free
    always_comb begin
        tx.txValid = (state == SEND);
        tx.txData  = (state == SEND) ? frameByte : 8'h00;
        busy       = (state == SEND) || (state == DONE);
        done       = (state == DONE);
    end
endmodule

// File: tb/tb_ex_mem_debug_reader.sv
// tb/tb_ex_mem_debug_reader.sv - self-checking bench for ex_mem_debug_reader
module tb_ex_mem_debug_reader;
`ifdef DEBUG_FRAME_CHECKSUM_EN
    localparam int FRAME_LEN = 12;
`else
    localparam int FRAME_LEN = 11;
`endif

    typedef logic [7:0] byteq_t[$];
    typedef struct {
        logic [4:0]        wr;
        logic [31:0]       wd;
        logic [31:0]       ao;
        logic              rw;
        logic              mtr;
        logic [3:0]        mw;
        logic [1:0]        mrw;
        logic              eop;
        int                readyPct;
        logic [0:11][7:0]  exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        debugReset = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  writeRegister = '0;
    logic [31:0] writeData = '0;
    logic [31:0] aluOut = '0;
    logic        regWrite = 1'b0;
    logic        memToReg = 1'b0;
    logic [3:0]  memWrite = '0;
    logic [1:0]  memReadWidth = '0;
    logic        eop = 1'b0;
    logic        busy;
    logic        done;

    int     checks = 0;
    int     failures = 0;
    byteq_t rxQ;
    int     doneSeen;
    int     doneCyc;

    ex_mem_debug_reader_if ifc();

    ex_mem_debug_reader dut (
        .clock(clock), .reset(reset), .debugReset(debugReset), .start(start),
        .writeRegister(writeRegister), .writeData(writeData), .aluOut(aluOut),
        .regWrite(regWrite), .memToReg(memToReg), .memWrite(memWrite),
        .memReadWidth(memReadWidth), .eop(eop), .tx(ifc), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Frame as the host sees it: header, register byte, two big-endian words, control byte
    function automatic byteq_t model(input vec_t v);
        byteq_t q;
        logic [7:0] x;
        q.push_back(8'hA5);
        q.push_back({v.eop, 2'b00, v.wr});
        for (int i = 3; i >= 0; i--) q.push_back(8'((v.wd >> (8 * i)) & 32'hFF));
        for (int i = 3; i >= 0; i--) q.push_back(8'((v.ao >> (8 * i)) & 32'hFF));
        q.push_back({v.rw, v.mtr, v.mw, v.mrw});
`ifdef DEBUG_FRAME_CHECKSUM_EN
        x = 8'h00;
        foreach (q[i]) x = x ^ q[i];
        q.push_back(x);
`else
        x = 8'h00;
`endif
        return q;
    endfunction

    function automatic logic [0:11][7:0] toArr(input byteq_t q);
        logic [0:11][7:0] r;
        r = '0;
        foreach (q[i]) if (i < 12) r[i] = q[i];
        return r;
    endfunction

    task automatic drive(input vec_t v);
        writeRegister = v.wr;
        writeData     = v.wd;
        aluOut        = v.ao;
        regWrite      = v.rw;
        memToReg      = v.mtr;
        memWrite      = v.mw;
        memReadWidth  = v.mrw;
        eop           = v.eop;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic collect(input int readyPct, input int stallAt, input int stallLen,
                           input logic [7:0] stallExp);
        logic [7:0] prevData;
        bit prevStall;
        int stalled;
        int cyc;
        prevData = 8'h00;
        prevStall = 1'b0;
        stalled = 0;
        cyc = 0;
        rxQ.delete();
        doneSeen = 0;
        doneCyc = -1;
        while (doneSeen == 0 && cyc < 400) begin
            if (prevStall)
                chk("hold_stable", 32'({ifc.txValid, ifc.txData}), 32'({1'b1, prevData}));
            if (done) begin
                doneSeen = 1;
                doneCyc = cyc;
            end else begin
                if (ifc.txValid && rxQ.size() == stallAt && stalled < stallLen) begin
                    ifc.txReady = 1'b0;
                    stalled++;
                    chk("stall_data", 32'(ifc.txData), 32'(stallExp));
                end else begin
                    ifc.txReady = ($urandom_range(99) < readyPct);
                end
                prevStall = ifc.txValid && !ifc.txReady;
                prevData = ifc.txData;
                if (ifc.txValid && ifc.txReady) rxQ.push_back(ifc.txData);
                @(negedge clock);
                cyc++;
            end
        end
        if (doneSeen == 0) begin
            chk("done_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_txvalid_low", 32'(ifc.txValid), 32'd0);
            chk("done_busy", 32'(busy), 32'd1);
            @(negedge clock);
            chk("done_one_cycle", 32'(done), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end
        ifc.txReady = 1'b1;
    endtask

    task automatic cmpFrame(input string tag, input logic [0:11][7:0] exp);
        chk({tag, "_len"}, 32'(rxQ.size()), 32'(FRAME_LEN));
        for (int i = 0; i < FRAME_LEN && i < rxQ.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(rxQ[i]), 32'(exp[i]));
    endtask

    task automatic quietWindow(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (done || busy) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        vec_t spec;
        int pcts[5];
        pcts = '{100, 75, 50, 30, 90};
        ifc.txReady = 1'b1;

        repeat (3) @(negedge clock);
        chk("rst_txvalid", 32'(ifc.txValid), 32'd0);
        chk("rst_txdata", 32'(ifc.txData), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        spec = '{wr: 5'd3, wd: 32'h12345678, ao: 32'hDEADBEEF, rw: 1'b1, mtr: 1'b0,
                 mw: 4'h0, mrw: 2'b10, eop: 1'b0, readyPct: 100,
                 exp: {8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78,
                       8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h82, 8'h0E}};
        vecs[0] = spec;
        for (int i = 1; i < 6; i++) begin
            vecs[i].wr       = 5'($urandom);
            vecs[i].wd       = $urandom;
            vecs[i].ao       = $urandom;
            vecs[i].rw       = 1'($urandom);
            vecs[i].mtr      = 1'($urandom);
            vecs[i].mw       = 4'($urandom);
            vecs[i].mrw      = 2'($urandom);
            vecs[i].eop      = 1'($urandom);
            vecs[i].readyPct = pcts[i-1];
            vecs[i].exp      = toArr(model(vecs[i]));
        end

        foreach (vecs[i]) begin
            drive(vecs[i]);
            pulseStart();
            collect(vecs[i].readyPct, -1, 0, 8'h00);
            cmpFrame($sformatf("vec%0d", i), vecs[i].exp);
            if (vecs[i].readyPct == 100) chk("latency", 32'(doneCyc), 32'(FRAME_LEN));
        end

        drive(spec);
        pulseStart();
        collect(100, 4, 5, 8'h56);
        cmpFrame("backpressure", spec.exp);

        drive(spec);
        pulseStart();
        fork
            collect(100, -1, 0, 8'h00);
            begin
                repeat (3) @(negedge clock);
                writeData = 32'hFFFFFFFF;
                aluOut = 32'h00000000;
                start = 1'b1;
                @(negedge clock);
                start = 1'b0;
            end
        join
        cmpFrame("freeze", spec.exp);
        quietWindow("freeze_single_done", 15);

        drive(spec);
        pulseStart();
        repeat (6) @(negedge clock);
        chk("abort_at_byte6", 32'(ifc.txData), 32'h000000DE);
        debugReset = 1'b1;
        @(negedge clock);
        debugReset = 1'b0;
        chk("abort_txvalid", 32'(ifc.txValid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        quietWindow("abort_no_done", 15);
        pulseStart();
        collect(100, -1, 0, 8'h00);
        cmpFrame("after_abort", spec.exp);

        drive(spec);
        pulseStart();
        repeat (4) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("areset_txvalid", 32'(ifc.txValid), 32'd0);
        chk("areset_txdata", 32'(ifc.txData), 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_done", 32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("areset_idle_busy", 32'(busy), 32'd0);
        drive(vecs[3]);
        pulseStart();
        collect(60, -1, 0, 8'h00);
        cmpFrame("after_reset", vecs[3].exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
